// File: rtl/fft_butterfly_pipe_if.sv
// Butterfly stream interface: one beat carries E, O, W and the inverse flag; results return on the same bundle.
interface fft_butterfly_pipe_if #(
    parameter int SAMPLE_W  = 16,
    parameter int TWIDDLE_W = 16
);
    logic                        in_valid;
    logic                        in_ready;
    logic                        inverse;
    logic signed [SAMPLE_W-1:0]  even_re;
    logic signed [SAMPLE_W-1:0]  even_im;
    logic signed [SAMPLE_W-1:0]  odd_re;
    logic signed [SAMPLE_W-1:0]  odd_im;
    logic signed [TWIDDLE_W-1:0] tw_re;
    logic signed [TWIDDLE_W-1:0] tw_im;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [SAMPLE_W-1:0]  sum_re;
    logic signed [SAMPLE_W-1:0]  sum_im;
    logic signed [SAMPLE_W-1:0]  diff_re;
    logic signed [SAMPLE_W-1:0]  diff_im;
    logic                        ovf;
    logic                        ovf_clr;

    modport slave (
        input  in_valid, inverse, even_re, even_im, odd_re, odd_im, tw_re, tw_im,
        input  out_ready, ovf_clr,
        output in_ready, out_valid, sum_re, sum_im, diff_re, diff_im, ovf
    );

    modport master (
        output in_valid, inverse, even_re, even_im, odd_re, odd_im, tw_re, tw_im,
        output out_ready, ovf_clr,
        input  in_ready, out_valid, sum_re, sum_im, diff_re, diff_im, ovf
    );
endinterface

// File: rtl/fft_butterfly_pipe.sv
// Radix-2 DIT butterfly X = E + W*O, Y = E - W*O with rounding, scaling and saturation.
// Latency 3 cycles accept-to-out_valid; one beat per cycle when unstalled.
// Backpressure: a held result (out_valid & ~out_ready) freezes every stage and drops in_ready.
module fft_butterfly_pipe #(
    parameter int SAMPLE_W    = 16,
    parameter int TWIDDLE_W   = 16,
    parameter int SCALE_SHIFT = 1
) (
    input logic                 clk,
    input logic                 rst,
    fft_butterfly_pipe_if.slave bus
);
    localparam int PW = SAMPLE_W + TWIDDLE_W;
    localparam int AW = SAMPLE_W + 2;

    localparam logic signed [TWIDDLE_W-1:0] TW_MIN = {1'b1, {(TWIDDLE_W-1){1'b0}}};
    localparam logic signed [TWIDDLE_W-1:0] TW_MAX = ~TW_MIN;
    localparam logic signed [PW:0]          RND_Q  = (PW+1)'(1) <<< (TWIDDLE_W-2);
    localparam logic signed [AW-1:0]        RND_S  = AW'((1 << SCALE_SHIFT) >> 1);
    localparam logic signed [AW-1:0]        S_MAX  = {3'b000, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [AW-1:0]        S_MIN  = {3'b111, {(SAMPLE_W-1){1'b0}}};

    typedef struct packed {
        logic signed [SAMPLE_W-1:0]  e_re, e_im, o_re, o_im;
        logic signed [TWIDDLE_W-1:0] w_re, w_im;
    } s1_t;

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] e_re, e_im;
        logic signed [PW-1:0]       rr, ii, ri, ir;
    } s2_t;

    s1_t s1_q, s1_d;
    s2_t s2_q, s2_d;
    logic s1_vld, s2_vld, s3_vld;
    logic adv;
    logic ovf_q;
    logic [3:0][SAMPLE_W-1:0] out_q;

    logic signed [PW:0]         p_re, p_im;
    logic signed [AW-1:0]       q_re, q_im, e_re_x, e_im_x;
    logic signed [AW-1:0]       lane [4];
    logic signed [AW-1:0]       lane_sc [4];
    logic [3:0][SAMPLE_W-1:0]   lane_sat;
    logic [3:0]                 clip;

    assign adv          = bus.out_ready | ~s3_vld;
    assign bus.in_ready = adv;
    assign bus.out_valid = s3_vld;
    assign bus.sum_re   = out_q[0];
    assign bus.sum_im   = out_q[1];
    assign bus.diff_re  = out_q[2];
    assign bus.diff_im  = out_q[3];
    assign bus.ovf      = ovf_q;

    // Conjugating W for the inverse transform; -1.0 has no positive twin, so it clips to +max.
    always_comb begin
        s1_d.e_re = bus.even_re;
        s1_d.e_im = bus.even_im;
        s1_d.o_re = bus.odd_re;
        s1_d.o_im = bus.odd_im;
        s1_d.w_re = bus.tw_re;
        s1_d.w_im = bus.tw_im;
        if (bus.inverse) s1_d.w_im = (bus.tw_im == TW_MIN) ? TW_MAX : -bus.tw_im;
    end

    always_comb begin
        s2_d.e_re = s1_q.e_re;
        s2_d.e_im = s1_q.e_im;
        s2_d.rr   = PW'($signed(s1_q.o_re)) * PW'($signed(s1_q.w_re));
        s2_d.ii   = PW'($signed(s1_q.o_im)) * PW'($signed(s1_q.w_im));
        s2_d.ri   = PW'($signed(s1_q.o_re)) * PW'($signed(s1_q.w_im));
        s2_d.ir   = PW'($signed(s1_q.o_im)) * PW'($signed(s1_q.w_re));
    end

    always_comb begin
        p_re   = $signed({s2_q.rr[PW-1], s2_q.rr}) - $signed({s2_q.ii[PW-1], s2_q.ii});
        p_im   = $signed({s2_q.ri[PW-1], s2_q.ri}) + $signed({s2_q.ir[PW-1], s2_q.ir});
        q_re   = AW'((p_re + RND_Q) >>> (TWIDDLE_W-1));
        q_im   = AW'((p_im + RND_Q) >>> (TWIDDLE_W-1));
        e_re_x = {{2{s2_q.e_re[SAMPLE_W-1]}}, s2_q.e_re};
        e_im_x = {{2{s2_q.e_im[SAMPLE_W-1]}}, s2_q.e_im};
        lane[0] = e_re_x + q_re;
        lane[1] = e_im_x + q_im;
        lane[2] = e_re_x - q_re;
        lane[3] = e_im_x - q_im;
        lane_sat = '0;
        clip     = '0;
        for (int k = 0; k < 4; k++) begin
            lane_sc[k] = (lane[k] + RND_S) >>> SCALE_SHIFT;
            if (lane_sc[k] > S_MAX) begin
                lane_sat[k] = S_MAX[SAMPLE_W-1:0];
                clip[k]     = 1'b1;
            end else if (lane_sc[k] < S_MIN) begin
                lane_sat[k] = S_MIN[SAMPLE_W-1:0];
                clip[k]     = 1'b1;
            end else begin
                lane_sat[k] = lane_sc[k][SAMPLE_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
            s3_vld <= 1'b0;
            s1_q   <= '0;
            s2_q   <= '0;
            out_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (adv) begin
                s1_vld <= bus.in_valid;
                s2_vld <= s1_vld;
                s3_vld <= s2_vld;
                s1_q   <= s1_d;
                s2_q   <= s2_d;
                if (s2_vld) out_q <= lane_sat;
            end
            // Clear wins over a saturation landing in the same cycle.
            if (bus.ovf_clr)                    ovf_q <= 1'b0;
            else if (adv && s2_vld && |clip)    ovf_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fft_butterfly_pipe.sv
// Drives two butterflies (unscaled and halved) with identical beats and checks both against an arithmetic model.
module tb_fft_butterfly_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   clr = 1'b0;
    always #5 clk = ~clk;

    fft_butterfly_pipe_if #(.SAMPLE_W(16), .TWIDDLE_W(16)) bus0 ();
    fft_butterfly_pipe_if #(.SAMPLE_W(16), .TWIDDLE_W(16)) bus1 ();

    fft_butterfly_pipe #(.SAMPLE_W(16), .TWIDDLE_W(16), .SCALE_SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave));
    fft_butterfly_pipe #(.SAMPLE_W(16), .TWIDDLE_W(16), .SCALE_SHIFT(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave));

    typedef struct packed {
        logic              inv;
        logic signed [15:0] e_re, e_im, o_re, o_im, w_re, w_im;
    } beat_t;
    typedef logic [3:0][15:0] lanes_t;   // 0 sum_re, 1 sum_im, 2 diff_re, 3 diff_im
    typedef struct packed { lanes_t r0; lanes_t r1; } exp_t;

    exp_t  sb[$];
    int    errors = 0;
    int    checks = 0;
    string ln[4] = '{"sum_re", "sum_im", "diff_re", "diff_im"};

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic beat_t mk(input int er, input int ei, input int o_r, input int oi,
                                 input int wr, input int wi, input bit inv);
        beat_t b;
        b.inv = inv;
        b.e_re = 16'(er); b.e_im = 16'(ei);
        b.o_re = 16'(o_r); b.o_im = 16'(oi);
        b.w_re = 16'(wr); b.w_im = 16'(wi);
        return b;
    endfunction

    function automatic logic [15:0] rv();
        case ($urandom_range(0, 7))
            0:       return 16'h8000;
            1:       return 16'h7fff;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic beat_t rnd_beat();
        beat_t b;
        b.inv = 1'($urandom);
        b.e_re = rv(); b.e_im = rv(); b.o_re = rv(); b.o_im = rv(); b.w_re = rv(); b.w_im = rv();
        return b;
    endfunction

    // Complex multiply with Q15 twiddle, round half up, optional halve, then clamp to 16 bits.
    function automatic lanes_t model(input beat_t b, input int sh);
        longint er, ei, o_r, oi, wr, wi, qr, qi;
        longint l[4];
        lanes_t r;
        er = $signed(b.e_re); ei = $signed(b.e_im);
        o_r = $signed(b.o_re); oi = $signed(b.o_im);
        wr = $signed(b.w_re); wi = $signed(b.w_im);
        if (b.inv) wi = (wi == -32768) ? 32767 : -wi;
        qr = (o_r * wr - oi * wi + 16384) >>> 15;
        qi = (o_r * wi + oi * wr + 16384) >>> 15;
        l[0] = er + qr; l[1] = ei + qi; l[2] = er - qr; l[3] = ei - qi;
        for (int k = 0; k < 4; k++) begin
            if (sh != 0) l[k] = (l[k] + 1) >>> 1;
            if (l[k] > 32767) l[k] = 32767;
            if (l[k] < -32768) l[k] = -32768;
            r[k] = 16'(l[k]);
        end
        return r;
    endfunction

    function automatic lanes_t got(input bit d);
        if (d) return {bus1.diff_im, bus1.diff_re, bus1.sum_im, bus1.sum_re};
        return {bus0.diff_im, bus0.diff_re, bus0.sum_im, bus0.sum_re};
    endfunction

    task automatic drive(input bit iv, input bit ordy, input beat_t b);
        bus0.in_valid = iv;  bus1.in_valid = iv;
        bus0.out_ready = ordy; bus1.out_ready = ordy;
        bus0.ovf_clr = clr;  bus1.ovf_clr = clr;
        bus0.inverse = b.inv; bus1.inverse = b.inv;
        bus0.even_re = b.e_re; bus1.even_re = b.e_re;
        bus0.even_im = b.e_im; bus1.even_im = b.e_im;
        bus0.odd_re = b.o_re;  bus1.odd_re = b.o_re;
        bus0.odd_im = b.o_im;  bus1.odd_im = b.o_im;
        bus0.tw_re = b.w_re;   bus1.tw_re = b.w_re;
        bus0.tw_im = b.w_im;   bus1.tw_im = b.w_im;
    endtask

    // One clock: drive at the falling edge, score the pending handshakes, wait for the next falling edge.
    task automatic step(input bit iv, input bit ordy, input beat_t b, output bit acc, output bit rdy);
        exp_t e;
        lanes_t g0, g1;
        drive(iv, ordy, b);
        #1;
        rdy = bus0.in_ready;
        acc = iv && bus0.in_ready;
        if (bus0.out_valid && ordy) begin
            if (sb.size() == 0) chk("unexpected_out", 1, 0);
            else begin
                e  = sb.pop_front();
                g0 = got(0);
                g1 = got(1);
                for (int k = 0; k < 4; k++) begin
                    chk($sformatf("sh0_%s", ln[k]), $signed(g0[k]), $signed(e.r0[k]));
                    chk($sformatf("sh1_%s", ln[k]), $signed(g1[k]), $signed(e.r1[k]));
                end
            end
        end
        if (acc) sb.push_back('{model(b, 0), model(b, 1)});
        @(negedge clk);
    endtask

    initial begin
        beat_t  idle, b;
        bit     acc, rdy, stalled;
        lanes_t snap;
        int     sent;
        idle = '0;
        drive(0, 0, idle);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_out_valid", bus0.out_valid, 0);
        chk("rst_in_ready", bus0.in_ready, 1);
        chk("rst_ovf", bus0.ovf, 0);
        chk("rst_data0", got(0), 0);
        chk("rst_data1", got(1), 0);
        rst = 1'b0;

        // Single beat: latency and hand-computed results for both scalings.
        step(1, 0, mk(1000, 0, 500, 0, 32767, 0, 0), acc, rdy);
        chk("lat_c1", bus0.out_valid, 0);
        step(0, 0, idle, acc, rdy);
        chk("lat_c2", bus0.out_valid, 0);
        step(0, 0, idle, acc, rdy);
        chk("lat_c3", bus0.out_valid, 1);
        chk("t1_sum_re", bus0.sum_re, 1500);
        chk("t1_diff_re", bus0.diff_re, 500);
        chk("t2_sum_re", bus1.sum_re, 750);
        chk("t2_diff_re", bus1.diff_re, 250);
        step(0, 1, idle, acc, rdy);

        // Twiddle of -j, forward then inverse.
        step(1, 0, mk(0, 0, 100, 0, 0, -32768, 0), acc, rdy);
        step(0, 0, idle, acc, rdy);
        step(0, 0, idle, acc, rdy);
        chk("fwd_sum_im", bus1.sum_im, -50);
        chk("fwd_diff_im", bus1.diff_im, 50);
        step(1, 1, mk(0, 0, 100, 0, 0, -32768, 1), acc, rdy);
        step(0, 0, idle, acc, rdy);
        step(0, 0, idle, acc, rdy);
        chk("inv_sum_im", bus1.sum_im, 50);
        chk("inv_diff_im", bus1.diff_im, -50);
        step(0, 1, idle, acc, rdy);

        // Saturation, sticky flag, clear, and clear colliding with a new saturation.
        b = mk(32767, 32767, 32767, 32767, 32767, 0, 0);
        step(1, 1, b, acc, rdy);
        step(0, 0, idle, acc, rdy);
        step(0, 0, idle, acc, rdy);
        chk("sat_sum_re", bus0.sum_re, 32767);
        chk("sat_sum_im", bus0.sum_im, 32767);
        chk("sat_diff_re", bus0.diff_re, 1);
        chk("ovf_set", bus0.ovf, 1);
        chk("ovf_scaled_clean", bus1.ovf, 0);
        step(0, 1, idle, acc, rdy);
        chk("ovf_sticky", bus0.ovf, 1);
        clr = 1'b1;
        step(0, 0, idle, acc, rdy);
        clr = 1'b0;
        chk("ovf_cleared", bus0.ovf, 0);
        clr = 1'b1;
        step(1, 1, b, acc, rdy);
        step(0, 0, idle, acc, rdy);
        step(0, 0, idle, acc, rdy);
        clr = 1'b0;
        chk("ovf_clr_priority", bus0.ovf, 0);
        step(0, 1, idle, acc, rdy);

        // Eight-beat burst with a downstream stall on cycles 4..9.
        sent = 0;
        for (int c = 0; c < 30; c++) begin
            bit ordy;
            ordy = !(c >= 4 && c <= 9);
            stalled = !ordy && bus0.out_valid;
            snap = got(0);
            step(sent < 8, ordy, rnd_beat(), acc, rdy);
            if (acc) sent++;
            if (stalled) begin
                chk("stall_in_ready", rdy, 0);
                chk("stall_hold_valid", bus0.out_valid, 1);
                chk("stall_hold_data", got(0), snap);
            end
        end
        chk("burst_sent", sent, 8);
        chk("burst_all_out", sb.size(), 0);

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) step(1, 1, rnd_beat(), acc, rdy);
        drive(0, 1, idle);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_out_valid", bus0.out_valid, 0);
        chk("mid_rst_in_ready", bus0.in_ready, 1);
        chk("mid_rst_data0", got(0), 0);
        chk("mid_rst_data1", got(1), 0);
        sb.delete();
        for (int i = 0; i < 6; i++) step(0, 1, idle, acc, rdy);
        chk("no_stale_beat", bus0.out_valid, 0);

        // Random traffic with random backpressure.
        for (int c = 0; c < 3000; c++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, rnd_beat(), acc, rdy);
        for (int c = 0; c < 20 && sb.size() != 0; c++) step(0, 1, idle, acc, rdy);
        chk("random_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
